// File: rtl/uriscv_muldiv.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-subtract step per cycle.
// Optional URISCV_MULDIV_EARLY_OUT_EN lets multiplies leave RUN once the multiplier is exhausted.
module uriscv_muldiv (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        valid_i,
   input  logic [2:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic        ready_o,
   output logic        valid_o,
   output logic [31:0] result_o
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned DLEN = 2 * XLEN;
   localparam int unsigned CW   = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state, state_d;
   logic [2:0]      op_q, op_d;
   logic [DLEN-1:0] acc, acc_d;
   logic [DLEN-1:0] mcand, mcand_d;
   logic [XLEN-1:0] mreg, mreg_d;
   logic [XLEN-1:0] rem, rem_d;
   logic [XLEN-1:0] result_d;
   logic [CW-1:0]   cnt, cnt_d;
   logic            neg_quo, neg_quo_d;
   logic            neg_rem, neg_rem_d;
   logic            ready_d, valid_d;
   logic            run_last;

   // Operand signedness and magnitudes at accept time
   logic            a_sgn, b_sgn;
   logic [XLEN-1:0] a_mag, b_mag;

   always_comb begin
      a_sgn = a_i[XLEN-1] & ((op_i == 3'b001) | (op_i == 3'b010) |
                             (op_i == 3'b100) | (op_i == 3'b110));
      b_sgn = b_i[XLEN-1] & ((op_i == 3'b001) | (op_i == 3'b100) | (op_i == 3'b110));
      a_mag = a_sgn ? XLEN'(-a_i) : a_i;
      b_mag = b_sgn ? XLEN'(-b_i) : b_i;
   end

   // One iteration of each datapath plus sign-corrected final values
   logic [DLEN-1:0] acc_step, prod;
   logic [XLEN-1:0] mul_shift, quo_step, rem_step, quo_fix, rem_fix, diff, final_res;
   logic [XLEN:0]   partial;
   logic            ge;

   always_comb begin
      acc_step  = mreg[0] ? DLEN'(acc + mcand) : acc;
      mul_shift = mreg >> 1;
      partial   = {rem, mreg[XLEN-1]};
      ge        = partial >= {1'b0, mcand[XLEN-1:0]};
      diff      = XLEN'(partial - {1'b0, mcand[XLEN-1:0]});
      rem_step  = ge ? diff : partial[XLEN-1:0];
      quo_step  = {mreg[XLEN-2:0], ge};
      prod      = neg_quo ? DLEN'(-acc_step) : acc_step;
      quo_fix   = neg_quo ? XLEN'(-quo_step) : quo_step;
      rem_fix   = neg_rem ? XLEN'(-rem_step) : rem_step;
      if (op_q[2]) begin
         final_res = op_q[1] ? rem_fix : quo_fix;
      end else begin
         final_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[DLEN-1:XLEN];
      end
   end

   // Next-state and datapath control
   always_comb begin
      state_d   = state;
      op_d      = op_q;
      acc_d     = acc;
      mcand_d   = mcand;
      mreg_d    = mreg;
      rem_d     = rem;
      cnt_d     = cnt;
      neg_quo_d = neg_quo;
      neg_rem_d = neg_rem;
      result_d  = result_o;
      run_last  = 1'b0;

      unique case (state)
         IDLE: begin
            if (valid_i) begin
               op_d      = op_i;
               acc_d     = '0;
               rem_d     = '0;
               cnt_d     = CW'(XLEN - 1);
               mcand_d   = DLEN'(op_i[2] ? b_mag : a_mag);
               mreg_d    = op_i[2] ? a_mag : b_mag;
               neg_quo_d = a_sgn ^ b_sgn;
               neg_rem_d = a_sgn & (op_i == 3'b110);
               // Divide by zero resolves immediately without iterating
               if (op_i[2] && (b_i == '0)) begin
                  state_d  = DONE;
                  result_d = op_i[1] ? a_i : '1;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            cnt_d = cnt - CW'(1);
            if (op_q[2]) begin
               mreg_d = quo_step;
               rem_d  = rem_step;
            end else begin
               acc_d   = acc_step;
               mcand_d = mcand << 1;
               mreg_d  = mul_shift;
            end
`ifdef URISCV_MULDIV_EARLY_OUT_EN
            run_last = (cnt == '0) || (!op_q[2] && (mul_shift == '0));
`else
            run_last = (cnt == '0);
`endif
            if (run_last) begin
               state_d  = DONE;
               result_d = final_res;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      ready_d = (state_d == IDLE);
      valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state    <= IDLE;
         op_q     <= '0;
         acc      <= '0;
         mcand    <= '0;
         mreg     <= '0;
         rem      <= '0;
         cnt      <= '0;
         neg_quo  <= 1'b0;
         neg_rem  <= 1'b0;
         ready_o  <= 1'b1;
         valid_o  <= 1'b0;
         result_o <= '0;
      end else begin
         state    <= state_d;
         op_q     <= op_d;
         acc      <= acc_d;
         mcand    <= mcand_d;
         mreg     <= mreg_d;
         rem      <= rem_d;
         cnt      <= cnt_d;
         neg_quo  <= neg_quo_d;
         neg_rem  <= neg_rem_d;
         ready_o  <= ready_d;
         valid_o  <= valid_d;
         result_o <= result_d;
      end
   end

endmodule

// File: tb/tb_uriscv_muldiv.sv
// Directed + random bench for uriscv_muldiv with an expected-result queue.
// Build with +define+URISCV_MULDIV_EARLY_OUT_EN to check early-out multiply timing.
module tb_uriscv_muldiv;

   logic        clk_i;
   logic        rst_i;
   logic        valid_i;
   logic [2:0]  op_i;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic        ready_o;
   logic        valid_o;
   logic [31:0] result_o;

   int          checks;
   int          errors;
   logic [31:0] exp_q[$];
   int          lat_q[$];

   uriscv_muldiv dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .valid_i (valid_i),
      .op_i    (op_i),
      .a_i     (a_i),
      .b_i     (b_i),
      .ready_o (ready_o),
      .valid_o (valid_o),
      .result_o(result_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference results from native wide arithmetic
   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] p;
      logic [31:0] r;
      int          sa;
      int          sb;
      sa = a;
      sb = b;
      r  = '0;
      case (op)
         3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
         3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[63:32]; end
         3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; r = p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
         3'd4: begin
            if (b == '0) r = '1;
            else if (a == 32'h8000_0000 && b == '1) r = a;
            else r = 32'(sa / sb);
         end
         3'd5: r = (b == '0) ? '1 : a / b;
         3'd6: begin
            if (b == '0) r = a;
            else if (a == 32'h8000_0000 && b == '1) r = '0;
            else r = 32'(sa % sb);
         end
         default: r = (b == '0) ? a : a % b;
      endcase
      return r;
   endfunction

   // Edges after the accept edge until valid_o is observed
   function automatic int exp_lat(input logic [2:0] op, input logic [31:0] b);
      if (op[2]) return (b == '0) ? 0 : 32;
`ifdef URISCV_MULDIV_EARLY_OUT_EN
      begin
         logic [31:0] m;
         int          n;
         m = (op == 3'd1 && b[31]) ? -b : b;
         n = 1;
         for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
         return n;
      end
`else
      return 32;
`endif
   endfunction

   task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
      int          n;
      bit          seen;
      bit          busy_ready;
      logic [31:0] e;
      int          l;
      n = 0;
      @(negedge clk_i);
      while (!ready_o && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      check({tag, " ready"}, 32'(ready_o), 32'd1);
      op_i    = op;
      a_i     = a;
      b_i     = b;
      valid_i = 1'b1;
      exp_q.push_back(exp);
      lat_q.push_back(exp_lat(op, b));
      @(posedge clk_i);
      #1;
      valid_i    = 1'b0;
      op_i       = 3'($urandom);
      a_i        = $urandom;
      b_i        = $urandom;
      n          = 0;
      seen       = valid_o;
      busy_ready = 1'b0;
      while (!seen && n < 40) begin
         if (ready_o) busy_ready = 1'b1;
         @(posedge clk_i);
         #1;
         n++;
         seen = valid_o;
      end
      e = exp_q.pop_front();
      l = lat_q.pop_front();
      check({tag, " result"}, result_o, e);
      check({tag, " latency"}, 32'(n), 32'(l));
      check({tag, " busy"}, 32'(busy_ready), 32'd0);
      @(posedge clk_i);
      #1;
      check({tag, " strobe"}, {30'b0, valid_o, ready_o}, 32'd1);
      check({tag, " hold"}, result_o, e);
   endtask

   initial begin
      bit          seen;
      logic [2:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      checks  = 0;
      errors  = 0;
      rst_i   = 1'b0;
      valid_i = 1'b0;
      op_i    = '0;
      a_i     = '0;
      b_i     = '0;
      repeat (3) @(posedge clk_i);
      #1;
      check("reset ready", 32'(ready_o), 32'd1);
      check("reset valid", 32'(valid_o), 32'd0);
      check("reset result", result_o, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b1;

      do_op("mul_7x3",   3'd0, 32'h0000_0007, 32'h0000_0003, 32'h0000_0015);
      do_op("mulh_m1",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
      do_op("mulhu_m1",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      do_op("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      do_op("mul_m1",    3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
      do_op("mul_b0",    3'd0, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000);
      do_op("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      do_op("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
      do_op("div_m7",    3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD);
      do_op("rem_m7",    3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF);
      do_op("divu_m7",   3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC);
      do_op("remu_m7",   3'd7, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001);
      do_op("divu_z",    3'd5, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF);
      do_op("rem_z",     3'd6, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234);

      for (int i = 0; i < 10; i++) begin
         rop = 3'(i % 8);
         ra  = $urandom;
         rb  = (i % 2 == 0) ? 32'($urandom_range(0, 300)) : $urandom;
         if (i == 7) rb = '0;
         if (i == 9) rb = -32'd5;
         do_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, model(rop, ra, rb));
      end

      // Reset in the middle of a divide, with a stray request during RUN
      @(negedge clk_i);
      op_i    = 3'd4;
      a_i     = 32'd1000;
      b_i     = 32'd7;
      valid_i = 1'b1;
      @(posedge clk_i);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk_i);
         valid_i = (k == 5);
         op_i    = 3'd0;
         rst_i   = (k != 10);
         @(posedge clk_i);
      end
      #1;
      check("mid_rst ready", 32'(ready_o), 32'd1);
      check("mid_rst valid", 32'(valid_o), 32'd0);
      check("mid_rst result", result_o, 32'd0);
      @(negedge clk_i);
      rst_i   = 1'b1;
      valid_i = 1'b0;
      seen    = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk_i);
         #1;
         if (valid_o || !ready_o) seen = 1'b1;
      end
      check("mid_rst no_strobe", 32'(seen), 32'd0);

      do_op("post_rst_div", 3'd4, 32'd1000, 32'd7, 32'd142);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
